pad_in_filter: RTL and testbench
================================

Name: pad_in_filter

Overview:
- Receive-side conditioner for a bidirectional pad.
- Takes the raw input bit that a pad cell returns to the core (pad_out of the inout pad cell), which is asynchronous to clk_i.
- Synchronizes it, rejects glitches with a programmable-length debounce, and produces a clean level plus single-cycle rise and fall event pulses.
- Sits between the pad ring and core consumers such as GPIO interrupt logic and wake-up detection.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the synchronizer chain; legal range 2..4.
- CNT_W, 16, width of the debounce counter and of debounce_cycles_i.
- RESET_VAL, 1'b0, reset value of the synchronizer chain and of level_o.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- pad_in_i  input  1  raw pad input bit, asynchronous to clk_i.
- en_i  input  1  filter enable.
- debounce_cycles_i  input  CNT_W  debounce threshold N, in clk_i cycles; quasi-static.
- level_o  output  1  filtered level.
- rise_o  output  1  one-cycle pulse when level_o goes 0->1.
- fall_o  output  1  one-cycle pulse when level_o goes 1->0.
- glitch_cnt_o  output  16  rejected-glitch count; present only with the optional feature.
- glitch_clr_i  input  1  clears glitch_cnt_o; present only with the optional feature.

Behaviour:
- Reset (rst_i=1 sampled at a clk_i edge):
  - sync chain = RESET_VAL; level_o = RESET_VAL.
  - rise_o = fall_o = 0; counter = 0; FSM = STABLE; glitch_cnt_o = 0.
  - Reset mid-debounce aborts the pending transition with no pulse.
- Synchronizer:
  - SYNC_STAGES flops, always clocking, independent of en_i.
  - s = last stage output.
- FSM states STABLE and PEND, with counter cnt (CNT_W bits):
  - STABLE, s==level_o: stay.
  - STABLE, s!=level_o, en_i=1, effective N<=1: flip level_o on this edge and stay in STABLE.
  - STABLE, s!=level_o, en_i=1, effective N>1: cnt<=1, go to PEND.
  - PEND, s==level_o: glitch rejected; cnt<=0, go to STABLE, level_o unchanged.
  - PEND, s!=level_o, cnt+1>=N: flip level_o, cnt<=0, go to STABLE.
  - PEND, s!=level_o, cnt+1<N: cnt<=cnt+1.
- Effective N:
  - N = debounce_cycles_i; N=0 behaves exactly as N=1 (no filtering).
  - Comparison is against the live value. If N is lowered below cnt while in PEND, the flip happens on the next differing sample.
  - cnt never wraps: the flip occurs at cnt+1==N, at most 2^CNT_W-1.
- Latency:
  - Pad edge arriving before clock edge k produces a level_o change after edge k+SYNC_STAGES+max(N,1)-1.
  - With defaults and N=1: level_o changes 2 cycles after the pad edge.
- Pulses:
  - rise_o/fall_o are registered and asserted in the same cycle level_o first shows its new value, for exactly one cycle.
  - rise_o and fall_o are never high together.
  - Back-to-back transitions are possible only when N<=1.
- en_i=0:
  - level_o holds; cnt<=0; FSM forced to STABLE; no pulses; sync chain keeps running.
  - On re-enable, a level difference is debounced from scratch; no event is generated for activity while disabled.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: PAD_IN_FILTER_GLITCH_CNT_EN.
- Defined:
  - Ports glitch_cnt_o and glitch_clr_i exist.
  - 16-bit counter increments on every PEND->STABLE transition without a flip; it saturates at 16'hFFFF.
  - glitch_clr_i=1 sets the counter to 0 on the next edge and takes priority over a simultaneous increment.
  - Reset clears the counter.
- Not defined: neither port nor the counter exists; all other behaviour is identical.

Test Plan:
- Reset with RESET_VAL=0, pad_in_i=1 held during reset -> level_o=0, no pulses. After release, with N=1, level_o=1 and rise_o=1 for one cycle at the 2nd edge after reset release.
- N=4, en_i=1, pad 0->1 held -> level_o rises SYNC_STAGES+3=5 cycles after the pad edge; rise_o high exactly 1 cycle; fall_o stays 0.
- N=4, pad pulse high for 3 cycles then low -> level_o stays 0, no rise_o. With the macro defined, glitch_cnt_o=1; a 1-cycle glitch_clr_i returns it to 0.
- N=0 versus N=1, pad toggled every 2 cycles -> identical level_o waveforms, each toggle followed by one matching rise_o or fall_o.
- en_i=0 while the pad goes 0->1 and is held, then en_i=1 with N=3 -> level_o stays 0 while disabled; after re-enable, level_o=1 and rise_o pulse 3 cycles later.
- N=1000 with pad held differing; at cnt=600 set N=500 -> flip on the next edge.
- Separately, rst_i asserted mid-PEND -> no flip, no pulse, state returns to reset values.

Source files
------------

// File: rtl/pad_in_filter.sv
// Pad receive conditioner: synchronizer, programmable debounce, clean level and edge pulses.
// Optional rejected-glitch counter enabled by defining PAD_IN_FILTER_GLITCH_CNT_EN.
module pad_in_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad_in_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] debounce_cycles_i,
`ifdef PAD_IN_FILTER_GLITCH_CNT_EN
  input  logic             glitch_clr_i,
  output logic [15:0]      glitch_cnt_o,
`endif
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o
);

  typedef enum logic [0:0] {StStable, StPend} state_e;

  localparam logic [CNT_W:0] CntOneWide = (CNT_W+1)'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   flip;
  logic [CNT_W:0]         n_eff;
  logic [CNT_W:0]         cnt_inc;

  assign s = sync_q[SYNC_STAGES-1];

  // N=0 is treated as N=1; one extra bit keeps cnt+1 from wrapping in the compare.
  assign n_eff   = (debounce_cycles_i == '0) ? CntOneWide : {1'b0, debounce_cycles_i};
  assign cnt_inc = {1'b0, cnt_q} + CntOneWide;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    if (!en_i) begin
      state_d = StStable;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StStable: begin
          if (s != level_q) begin
            if (n_eff <= CntOneWide) begin
              flip = 1'b1;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = StPend;
            end
          end
        end
        StPend: begin
          if (s == level_q) begin
            cnt_d   = '0;
            state_d = StStable;
          end else if (cnt_inc >= n_eff) begin
            flip    = 1'b1;
            cnt_d   = '0;
            state_d = StStable;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StStable;
        end
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (flip) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      fall_d  = level_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      state_q <= StStable;
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_in_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef PAD_IN_FILTER_GLITCH_CNT_EN
  logic [15:0] glitch_cnt_q, glitch_cnt_d;
  logic        glitch_inc;

  // Any exit from PEND that does not flip the level counts as a rejected glitch.
  assign glitch_inc = (state_q == StPend) && (state_d == StStable) && !flip;

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr_i) begin
      glitch_cnt_d = '0;
    end else if (glitch_inc && (glitch_cnt_q != 16'hFFFF)) begin
      glitch_cnt_d = glitch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_pad_in_filter.sv
// Self-checking bench for pad_in_filter: directed scenarios plus randomized stimulus
// compared every cycle against a run-length reference model.
module tb_pad_in_filter;

  localparam int unsigned SS    = 2;
  localparam int unsigned CNT_W = 16;
  localparam logic        RV    = 1'b0;

  logic             clk = 1'b0;
  logic             rst;
  logic             pad;
  logic             en;
  logic [CNT_W-1:0] n_cyc;
  logic             level, rise, fall;
`ifdef PAD_IN_FILTER_GLITCH_CNT_EN
  logic             gclr;
  logic [15:0]      gcnt;
`endif

  pad_in_filter #(
    .SYNC_STAGES(SS),
    .CNT_W      (CNT_W),
    .RESET_VAL  (RV)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pad_in_i         (pad),
    .en_i             (en),
    .debounce_cycles_i(n_cyc),
`ifdef PAD_IN_FILTER_GLITCH_CNT_EN
    .glitch_clr_i     (gclr),
    .glitch_cnt_o     (gcnt),
`endif
    .level_o          (level),
    .rise_o           (rise),
    .fall_o           (fall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pad history delay line and a run length of differing samples.
  logic m_sync[SS];
  logic m_level, m_rise, m_fall;
  int   m_run;
  int   m_gcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    logic s;
    int   neff;
    logic pend;
    logic ginc;
    @(posedge clk);
    s      = m_sync[SS-1];
    m_rise = 1'b0;
    m_fall = 1'b0;
    ginc   = 1'b0;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_sync[i] = RV;
      m_level = RV;
      m_run   = 0;
      m_gcnt  = 0;
    end else begin
      neff = (n_cyc == 0) ? 1 : int'(n_cyc);
      pend = (m_run > 0);
      if (!en) begin
        ginc  = pend;
        m_run = 0;
      end else if (s == m_level) begin
        ginc  = pend;
        m_run = 0;
      end else begin
        m_run++;
        if (m_run >= neff) begin
          m_level = ~m_level;
          m_rise  = m_level;
          m_fall  = ~m_level;
          m_run   = 0;
        end
      end
`ifdef PAD_IN_FILTER_GLITCH_CNT_EN
      if (gclr) m_gcnt = 0;
      else if (ginc && m_gcnt < 16'hFFFF) m_gcnt++;
`endif
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = pad;
    end
    #1;
    chk("level", {31'b0, level}, {31'b0, m_level});
    chk("rise", {31'b0, rise}, {31'b0, m_rise});
    chk("fall", {31'b0, fall}, {31'b0, m_fall});
    chk("rise_fall_excl", {31'b0, rise & fall}, 32'd0);
`ifdef PAD_IN_FILTER_GLITCH_CNT_EN
    chk("glitch_cnt", {16'b0, gcnt}, m_gcnt);
`endif
  endtask

  // Steps until level equals want; returns edges taken (budget+1 on timeout).
  task automatic wait_level(input logic want, input int budget, output int edges,
                            output int rises, output int falls);
    edges = 0;
    rises = 0;
    falls = 0;
    while (edges <= budget) begin
      step();
      edges++;
      rises += int'(rise);
      falls += int'(fall);
      if (level == want) break;
    end
  endtask

  int   edges, rises, falls, diffs, hold;
  logic wave0[40];
  logic wave1[40];

  initial begin
    rst   = 1'b1;
    pad   = 1'b1;
    en    = 1'b1;
    n_cyc = 16'd1;
`ifdef PAD_IN_FILTER_GLITCH_CNT_EN
    gclr  = 1'b0;
`endif
    for (int i = 0; i < SS; i++) m_sync[i] = 1'bx;
    m_level = 1'bx;
    m_run   = 0;
    m_gcnt  = 0;

    // Reset with pad high: level held at reset value, then rises via N=1.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step();
    chk("reset_level", {31'b0, level}, {31'b0, RV});
    rst = 1'b0;
    wait_level(1'b1, 10, edges, rises, falls);
    chk("rst_release_latency", edges, SS + 1);
    chk("rst_release_rise", rises, 1);

    // N=4: pad 1->0 then 0->1 held, latency SS+N edges counting the capture edge.
    n_cyc = 16'd4;
    pad   = 1'b0;
    wait_level(1'b0, 20, edges, rises, falls);
    for (int i = 0; i < 5; i++) step();
    pad = 1'b1;
    wait_level(1'b1, 20, edges, rises, falls);
    chk("n4_latency", edges, SS + 4);
    for (int i = 0; i < 6; i++) begin
      step();
      rises += int'(rise);
      falls += int'(fall);
    end
    chk("n4_rise_count", rises, 1);
    chk("n4_fall_count", falls, 0);

    // N=4: 3-cycle high pulse is rejected.
    pad = 1'b0;
    wait_level(1'b0, 20, edges, rises, falls);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    pad   = 1'b1;
    rises = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) pad = 1'b0;
      step();
      rises += int'(rise);
    end
    chk("glitch_level", {31'b0, level}, 32'd0);
    chk("glitch_no_rise", rises, 0);
`ifdef PAD_IN_FILTER_GLITCH_CNT_EN
    chk("glitch_cnt_one", {16'b0, gcnt}, 32'd1);
    gclr = 1'b1;
    step();
    gclr = 1'b0;
    chk("glitch_cnt_clr", {16'b0, gcnt}, 32'd0);
`endif

    // N=0 and N=1 produce identical waveforms for a pad toggling every 2 cycles.
    for (int pass = 0; pass < 2; pass++) begin
      n_cyc = (pass == 0) ? 16'd0 : 16'd1;
      pad   = 1'b0;
      for (int i = 0; i < 8; i++) step();
      for (int i = 0; i < 40; i++) begin
        if (i % 2 == 0) pad = ~pad;
        step();
        if (pass == 0) wave0[i] = level;
        else wave1[i] = level;
      end
    end
    diffs = 0;
    for (int i = 0; i < 40; i++) if (wave0[i] !== wave1[i]) diffs++;
    chk("n0_vs_n1_wave", diffs, 0);

    // Disabled while pad rises; re-enable with N=3 flips on the 3rd enabled edge.
    pad = 1'b0;
    for (int i = 0; i < 6; i++) step();
    en  = 1'b0;
    pad = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("disabled_hold", {31'b0, level}, 32'd0);
    en    = 1'b1;
    n_cyc = 16'd3;
    wait_level(1'b1, 20, edges, rises, falls);
    chk("reenable_latency", edges, 3);
    chk("reenable_rise", rises, 1);

    // Lowering N below the running count flips on the next differing sample.
    n_cyc = 16'd1000;
    pad   = 1'b0;
    hold  = 0;
    while (m_run != 600 && hold < 2000) begin
      step();
      hold++;
    end
    chk("n_lower_reach_600", m_run, 600);
    n_cyc = 16'd500;
    step();
    chk("n_lower_flip", {31'b0, level}, 32'd0);
    chk("n_lower_fall", {31'b0, fall}, 32'd1);

    // Reset mid-PEND aborts the transition.
    n_cyc = 16'd10;
    pad   = 1'b1;
    for (int i = 0; i < SS + 4; i++) step();
    rst = 1'b1;
    step();
    chk("rst_pend_level", {31'b0, level}, {31'b0, RV});
    chk("rst_pend_rise", {31'b0, rise}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rst_pend_restart", {31'b0, level}, {31'b0, RV});

    // Randomized traffic.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        pad  = ~pad;
        hold = $urandom_range(1, 8);
      end
      hold--;
      if (c % 50 == 0) n_cyc = CNT_W'($urandom_range(0, 6));
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
`ifdef PAD_IN_FILTER_GLITCH_CNT_EN
      gclr = ($urandom_range(0, 99) == 0);
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
